// File: rtl/issue_pkg.sv
// Shared types and constants for the issue-stage register scoreboard.
package issue_pkg;

  localparam int NREGS  = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  typedef logic [REG_AW-1:0] regaddr_t;
  typedef logic [CNT_W-1:0]  sbcnt_t;

  // Largest number of writes that may be outstanding to one register.
  localparam sbcnt_t CNT_MAX = '1;

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// Per-register in-flight write counter: up on issue, down on commit,
// cleared by flush. A commit seen with the counter already at zero leaves
// it at zero and raises a one-cycle underflow indication instead.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_count;
  logic             w_dec_ok;

  // Only a non-empty counter can retire a write.
  assign w_dec_ok    = i_dec && (r_count != '0);
  assign o_underflow = i_dec && (r_count == '0) && !i_clr;
  assign o_count     = r_count;

  // Count tracking; simultaneous inc and valid dec cancel out.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_dec_ok) begin
      r_count <= r_count + CNT_W'(1);
    end else if (!i_inc && w_dec_ok) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage register hazard controller. Holds back a decoded instruction
// while any register it reads, or a saturated destination, still has an
// uncommitted write in flight. Same-cycle commits are bypassed so a register
// retiring this cycle does not block issue.
module issue_scoreboard
#(
  parameter int NREGS   = 32,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    dec_valid,
  input  issue_pkg::regaddr_t     dec_rs1,
  input  issue_pkg::regaddr_t     dec_rs2,
  input  logic                    dec_use_rs1,
  input  logic                    dec_use_rs2,
  input  issue_pkg::regaddr_t     dec_rd,
  input  logic                    dec_we,
  input  logic                    we_c,
  input  issue_pkg::regaddr_t     rdaddr,
  input  logic                    flush,
  output logic                    issue_ready,
  output logic [NREGS-1:0]        pending,
  output logic [STALL_W-1:0]      stall_cnt,
  output logic                    err_underflow
);

  import issue_pkg::regaddr_t;

  localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

  logic [CNT_W-1:0]   w_cnt [NREGS];
  logic [CNT_W-1:0]   w_eff [NREGS];
  logic [NREGS-1:0]   w_hit;
  logic [NREGS-1:0]   w_uf;
  logic [NREGS-1:0]   w_busy;
  logic               w_raw1;
  logic               w_raw2;
  logic               w_sat;
  logic               w_issue_ready;
  logic               w_fire;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_err_underflow;

  // x0 is hardwired zero: never busy, never counted.
  assign w_cnt[0]  = '0;
  assign w_eff[0]  = '0;
  assign w_hit[0]  = 1'b0;
  assign w_uf[0]   = 1'b0;
  assign w_busy[0] = 1'b0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    logic w_commit;
    logic w_inc;

    assign w_commit   = we_c && (rdaddr == regaddr_t'(gi));
    assign w_inc      = w_fire && dec_we && (dec_rd == regaddr_t'(gi));
    assign w_hit[gi]  = w_commit && (w_cnt[gi] != '0);
    assign w_eff[gi]  = w_cnt[gi] - {{(CNT_W-1){1'b0}}, w_hit[gi]};
    assign w_busy[gi] = (w_cnt[gi] != '0);

    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk         (clk),
      .nrst        (nrst),
      .i_inc       (w_inc),
      .i_dec       (w_commit),
      .i_clr       (flush),
      .o_count     (w_cnt[gi]),
      .o_underflow (w_uf[gi])
    );
  end

  // Hazard checks use the post-commit (bypassed) counts. The instruction's
  // own destination increment is not yet in the counters, so it never
  // blocks itself.
  assign w_raw1 = dec_use_rs1 && (dec_rs1 != '0) && (w_eff[dec_rs1] != '0);
  assign w_raw2 = dec_use_rs2 && (dec_rs2 != '0) && (w_eff[dec_rs2] != '0);
  assign w_sat  = dec_we && (dec_rd != '0) && (w_eff[dec_rd] == L_CNT_MAX);

  assign w_issue_ready = !flush && !(w_raw1 || w_raw2 || w_sat);
  assign w_fire        = dec_valid && w_issue_ready;

  // Saturating count of cycles decode was held back (flush cycles excluded).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_stall_cnt <= '0;
    end else if (dec_valid && !w_issue_ready && !flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  // Sticky flag for a commit to a register with nothing outstanding.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_err_underflow <= 1'b0;
    end else if (|w_uf) begin
      r_err_underflow <= 1'b1;
    end
  end

  assign issue_ready   = w_issue_ready;
  assign pending       = w_busy;
  assign stall_cnt     = r_stall_cnt;
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a cycle-by-cycle vector table plus a
// few hand-written sequences for self-overlap, bypass and async reset.
module tb_issue_scoreboard;

  logic        clk;
  logic        nrst;
  logic        dec_valid;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_use_rs1;
  logic        dec_use_rs2;
  logic [4:0]  dec_rd;
  logic        dec_we;
  logic        we_c;
  logic [4:0]  rdaddr;
  logic        flush;
  logic        issue_ready;
  logic [31:0] pending;
  logic [15:0] stall_cnt;
  logic        err_underflow;

  int n_checks = 0;
  int n_errors = 0;

  issue_scoreboard #(
    .NREGS   (32),
    .CNT_W   (2),
    .STALL_W (16)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .dec_valid     (dec_valid),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_use_rs1   (dec_use_rs1),
    .dec_use_rs2   (dec_use_rs2),
    .dec_rd        (dec_rd),
    .dec_we        (dec_we),
    .we_c          (we_c),
    .rdaddr        (rdaddr),
    .flush         (flush),
    .issue_ready   (issue_ready),
    .pending       (pending),
    .stall_cnt     (stall_cnt),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        we;
    logic        wec;
    logic [4:0]  ra;
    logic        fl;
    logic        exp_ready;
    logic [31:0] exp_pend;
    logic [15:0] exp_stall;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd, input logic we,
                              input logic wec, input logic [4:0] ra, input logic fl,
                              input logic er, input logic [31:0] ep, input logic [15:0] es,
                              input logic ee);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.we = we; v.wec = wec; v.ra = ra; v.fl = fl;
    v.exp_ready = er; v.exp_pend = ep; v.exp_stall = es; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    dec_valid   = v.valid;
    dec_rs1     = v.rs1;
    dec_rs2     = v.rs2;
    dec_use_rs1 = v.u1;
    dec_use_rs2 = v.u2;
    dec_rd      = v.rd;
    dec_we      = v.we;
    we_c        = v.wec;
    rdaddr      = v.ra;
    flush       = v.fl;
  endtask

  // Drive at the falling edge, check 1ns later, well clear of the rising edge.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    $display("%s ready=%b pending=%h stall=%0d err=%b", tag, issue_ready, pending, stall_cnt, err_underflow);
    chk({tag, ".ready"}, {31'd0, issue_ready},   {31'd0, v.exp_ready});
    chk({tag, ".pend"},  pending,                v.exp_pend);
    chk({tag, ".stall"}, {16'd0, stall_cnt},     {16'd0, v.exp_stall});
    chk({tag, ".err"},   {31'd0, err_underflow}, {31'd0, v.exp_err});
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0);
    drive(idle);
    nrst = 1'b0;
    #12;
    chk("rst.ready", {31'd0, issue_ready},   32'd1);
    chk("rst.pend",  pending,                32'd0);
    chk("rst.stall", {16'd0, stall_cnt},     32'd0);
    chk("rst.err",   {31'd0, err_underflow}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    //          vld rs1 rs2 u1 u2 rd we wc ra fl | rdy pend      stall err
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0,     0, 0));
    vecs.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0,  1, 32'h0,     0, 0));
    vecs.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  0, 32'h20,    0, 0));
    vecs.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  0, 32'h20,    1, 0));
    vecs.push_back(mk(1, 5, 0, 1, 0, 0, 0, 1, 5, 0,  1, 32'h20,    2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0,     2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 32'h0,     2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 32'h80,    2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 32'h80,    2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 32'h80,    2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 7, 0,  1, 32'h80,    3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 32'h80,    3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  1, 32'h80,    3, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0,  1, 32'h80,    3, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 0,  1, 32'h80,    3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,  1, 32'h80,    3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  1, 32'h84,    3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,10, 1, 0, 0, 0,  1, 32'hC4,    3, 0));
    vecs.push_back(mk(1, 2, 0, 1, 0,10, 1, 1,11, 1,  0, 32'h4C4,   3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0,     3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  1, 32'h0,     3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  1, 32'h10,    3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h10,    3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0,  1, 32'h10,    3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0,     3, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // rs1 == rs2 == rd: own increment invisible, then blocks the next copy;
    // rs2-only RAW; same-cycle commit bypass with simultaneous re-issue.
    apply("self0",  mk(1,12,12,1,1,12,1,0, 0,0, 1, 32'h0,    3, 1));
    apply("self1",  mk(1,12,12,1,1,12,1,0, 0,0, 0, 32'h1000, 3, 1));
    apply("rs2raw", mk(1, 0,12,0,1, 0,0,0, 0,0, 0, 32'h1000, 4, 1));
    apply("bypass", mk(1,12,12,1,1,12,1,1,12,0, 1, 32'h1000, 5, 1));
    apply("hold",   mk(0, 0, 0,0,0, 0,0,0, 0,0, 1, 32'h1000, 5, 1));
    apply("stallA", mk(1,12, 0,1,0, 0,0,0, 0,0, 0, 32'h1000, 5, 1));
    apply("stallB", mk(1,12, 0,1,0, 0,0,0, 0,0, 0, 32'h1000, 6, 1));

    // Asynchronous reset in the middle of a stall, away from any clock edge.
    #1;
    nrst = 1'b0;
    #1;
    $display("async_rst ready=%b pending=%h stall=%0d err=%b", issue_ready, pending, stall_cnt, err_underflow);
    chk("arst.ready", {31'd0, issue_ready},   32'd1);
    chk("arst.pend",  pending,                32'd0);
    chk("arst.stall", {16'd0, stall_cnt},     32'd0);
    chk("arst.err",   {31'd0, err_underflow}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    apply("post_rst", mk(0,0,0,0,0,0,0,0,0,0, 1, 32'h0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
